// File: rtl/sram_sweep_ctrl.sv
// Raster sweep sequencer for the parallel frame SRAM: issues NLANE-wide read beats plus a
// clamped right-neighbour address, and replays each beat as a write-back PIPE_LAT cycles later.
module sram_sweep_ctrl #(
    parameter int COLS     = 80,
    parameter int ROWS     = 60,
    parameter int AW       = 13,
    parameter int NLANE    = 5,
    parameter int PIPE_LAT = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [7:0]                i_num_iter,
    input  logic                      i_abort,
    input  logic                      i_stall,
    output logic [(NLANE+1)*AW-1:0]   o_rd_addr,
    output logic                      o_rd_valid,
    output logic [NLANE-1:0]          o_wr_en,
    output logic [NLANE*AW-1:0]       o_wr_addr,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [7:0]                o_iter
);

    localparam int NPIX = COLS * ROWS;
    localparam int DW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [AW-1:0] LAST_BASE  = AW'(NPIX - NLANE);
    localparam logic [AW-1:0] MAX_ADDR   = AW'(NPIX - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

    generate
        if (COLS % NLANE != 0) begin : g_bad_nlane
            $error("sram_sweep_ctrl: COLS must be a multiple of NLANE");
        end
        if (PIPE_LAT < 1) begin : g_bad_lat
            $error("sram_sweep_ctrl: PIPE_LAT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_base;
    logic [7:0]      r_iter;
    logic [7:0]      r_num_iter;
    logic [DW-1:0]   r_dcnt;
    logic            r_pv    [PIPE_LAT];
    logic [AW-1:0]   r_pbase [PIPE_LAT];

    logic w_run, w_hold, w_issue, w_flush, w_accept;
    logic w_last_beat, w_drain_end, w_more, w_wr_go;
    logic [AW-1:0] w_nbr;

    assign w_run       = (r_state == S_SWEEP) || (r_state == S_DRAIN);
    assign w_hold      = w_run && i_stall;
    assign w_flush     = i_abort && (r_state != S_IDLE);
    assign w_accept    = (r_state == S_IDLE) && i_start;
    assign w_issue     = (r_state == S_SWEEP) && !i_stall && !i_abort;
    assign w_last_beat = w_issue && (r_base == LAST_BASE);
    assign w_drain_end = (r_state == S_DRAIN) && !i_stall && !i_abort && (r_dcnt == DRAIN_LAST);
    assign w_more      = ({1'b0, r_iter} + 9'd1) < {1'b0, r_num_iter};
    assign w_wr_go     = r_pv[PIPE_LAT-1] && !w_hold;
    assign w_nbr       = (r_base + AW'(NLANE) > MAX_ADDR) ? MAX_ADDR : r_base + AW'(NLANE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Abort overrides every other transition, including the last-beat and drain-end ones.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = (i_num_iter != 8'd0) ? S_SWEEP : S_DONE;
            S_SWEEP: if (w_last_beat) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_end) w_state_nxt = w_more ? S_SWEEP : S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_base     <= '0;
            r_iter     <= '0;
            r_num_iter <= '0;
            r_dcnt     <= '0;
        end else begin
            if (w_accept) begin
                r_base     <= '0;
                r_iter     <= '0;
                r_num_iter <= i_num_iter;
            end else if (w_issue) begin
                r_base <= r_base + AW'(NLANE);
            end else if (w_drain_end) begin
                r_base <= '0;
                r_iter <= r_iter + 8'd1;
            end
            if (r_state == S_SWEEP)
                r_dcnt <= '0;
            else if ((r_state == S_DRAIN) && !i_stall)
                r_dcnt <= r_dcnt + DW'(1);
        end
    end

    // Write-back pipe stores only the beat base; lane offsets are re-added on the way out.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_pv[i]    <= 1'b0;
                r_pbase[i] <= '0;
            end
        end else if (w_flush) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_pv[i]    <= 1'b0;
                r_pbase[i] <= '0;
            end
        end else if (!w_hold) begin
            r_pv[0]    <= w_issue;
            r_pbase[0] <= r_base;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_pv[i]    <= r_pv[i-1];
                r_pbase[i] <= r_pbase[i-1];
            end
        end
    end

    always_comb begin
        o_rd_addr = '0;
        o_wr_addr = '0;
        if (w_issue) begin
            for (int k = 0; k < NLANE; k++)
                o_rd_addr[k*AW +: AW] = r_base + AW'(k);
            o_rd_addr[NLANE*AW +: AW] = w_nbr;
        end
        if (w_wr_go) begin
            for (int k = 0; k < NLANE; k++)
                o_wr_addr[k*AW +: AW] = r_pbase[PIPE_LAT-1] + AW'(k);
        end
    end

    assign o_rd_valid = w_issue;
    assign o_wr_en    = {NLANE{w_wr_go}};
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_iter     = r_iter;

endmodule

// File: tb/tb_sram_sweep_ctrl.sv
// Directed bench for sram_sweep_ctrl: a table of run scenarios with hand-computed lengths,
// a read/write scoreboard per run, and hand-written reset sequences.
module tb_sram_sweep_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int AW    = 13;
  localparam int NLANE = 5;
  localparam int PL    = 2;
  localparam int NPIX  = COLS * ROWS;
  localparam int BEATS = NPIX / NLANE;

  // clock / reset
  logic clk = 1'b0;
  logic i_rst;
  always #5 clk = ~clk;

  logic                    i_start, i_abort, i_stall;
  logic [7:0]              i_num_iter;
  logic [(NLANE+1)*AW-1:0] o_rd_addr;
  logic                    o_rd_valid;
  logic [NLANE-1:0]        o_wr_en;
  logic [NLANE*AW-1:0]     o_wr_addr;
  logic                    o_busy, o_done;
  logic [7:0]              o_iter;

  sram_sweep_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .AW(AW), .NLANE(NLANE), .PIPE_LAT(PL)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_num_iter(i_num_iter),
    .i_abort(i_abort), .i_stall(i_stall), .o_rd_addr(o_rd_addr), .o_rd_valid(o_rd_valid),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_busy(o_busy), .o_done(o_done),
    .o_iter(o_iter)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_rd_addr"}, 64'(o_rd_addr != '0), 64'd0);
    chk({name, "_rd_valid"}, 64'(o_rd_valid), 64'd0);
    chk({name, "_wr_en"}, 64'(o_wr_en), 64'd0);
    chk({name, "_wr_addr"}, 64'(o_wr_addr != '0), 64'd0);
    chk({name, "_busy"}, 64'(o_busy), 64'd0);
    chk({name, "_done"}, 64'(o_done), 64'd0);
    chk({name, "_iter"}, 64'(o_iter), 64'd0);
  endtask

  // scenario record: inputs, then hand-computed expectations (done period counted from the
  // cycle i_start is high; -1 means no o_done expected)
  typedef struct {
    int num_iter;
    int stall_at;
    int stall_len;
    int abort_at;
    int busy_start_at;
    int exp_done;
    int exp_beats;
    int exp_iter;
  } case_t;

  case_t cases[6];

  // driver + scoreboard for one run
  task automatic run_case(input case_t c);
    logic [AW-1:0] exp_q[$];
    int            due_q[$];
    int beats = 0, ns = 0, dones = 0, done_at = -1, abort_p = -1;
    int stall_left, limit, exp_base;
    logic [AW-1:0] nbr;
    stall_left = c.stall_len;
    limit = ((c.exp_done > 0) ? c.exp_done : 600) + 30;
    @(posedge clk); #1;
    i_start = 1'b1; i_num_iter = 8'(c.num_iter); i_stall = 1'b0; i_abort = 1'b0;
    @(negedge clk);
    chk("busy_before_start", 64'(o_busy), 64'd0);
    for (int p = 1; p <= limit; p++) begin
      @(posedge clk); #1;
      i_start    = (p == c.busy_start_at);
      i_num_iter = (p == c.busy_start_at) ? 8'd5 : 8'(c.num_iter);
      i_stall    = (beats == c.stall_at) && (stall_left > 0);
      if (i_stall) stall_left--;
      i_abort    = (c.abort_at >= 0) && (beats == c.abort_at) && (abort_p < 0);
      @(negedge clk);
      if (p == 1) chk("busy_after_start", 64'(o_busy), 64'd1);
      if (abort_p >= 0 && p == abort_p + 1) begin
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_wr_en", 64'(o_wr_en), 64'd0);
        chk("abort_rd_valid", 64'(o_rd_valid), 64'd0);
      end
      if (i_stall) begin
        chk("stall_rd_valid", 64'(o_rd_valid), 64'd0);
        chk("stall_wr_en", 64'(o_wr_en), 64'd0);
      end else begin
        if (o_wr_en != '0) begin
          if (exp_q.size() == 0) begin
            chk("wr_unexpected", 64'(o_wr_en), 64'd0);
          end else begin
            chk("wr_en_lanes", 64'(o_wr_en), 64'({NLANE{1'b1}}));
            chk("wr_latency", 64'(ns), 64'(due_q[0]));
            for (int k = 0; k < NLANE; k++)
              chk("wr_addr", 64'(o_wr_addr[k*AW +: AW]), 64'(exp_q[0] + AW'(k)));
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
          end
        end else if (due_q.size() > 0 && due_q[0] <= ns) begin
          chk("wr_missing", 64'(o_wr_en), 64'({NLANE{1'b1}}));
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
        if (o_rd_valid) begin
          exp_base = (beats % BEATS) * NLANE;
          nbr = (exp_base + NLANE > NPIX - 1) ? AW'(NPIX - 1) : AW'(exp_base + NLANE);
          for (int k = 0; k < NLANE; k++)
            chk("rd_addr", 64'(o_rd_addr[k*AW +: AW]), 64'(exp_base + k));
          chk("rd_nbr", 64'(o_rd_addr[NLANE*AW +: AW]), 64'(nbr));
          if (exp_base == 0) begin
            chk("raw_order_pipe_empty", 64'(exp_q.size()), 64'd0);
            chk("iter_at_sweep_start", 64'(o_iter), 64'(beats / BEATS));
          end
          if (exp_base == NPIX - NLANE)
            chk("last_beat_nbr_clamp", 64'(o_rd_addr[NLANE*AW +: AW]), 64'(NPIX - 1));
          exp_q.push_back(AW'(exp_base));
          due_q.push_back(ns + PL);
          beats++;
        end
        ns++;
      end
      if (o_done) begin
        dones++;
        if (done_at < 0) done_at = p;
        chk("iter_at_done", 64'(o_iter), 64'(c.exp_iter));
      end
      if (i_abort) begin
        abort_p = p;
        exp_q.delete();
        due_q.delete();
      end
    end
    i_start = 1'b0; i_stall = 1'b0; i_abort = 1'b0;
    chk("done_pulses", 64'(dones), 64'((c.exp_done > 0) ? 1 : 0));
    if (c.exp_done > 0) chk("done_cycle", 64'(done_at), 64'(c.exp_done));
    chk("beat_count", 64'(beats), 64'(c.exp_beats));
    chk("final_iter", 64'(o_iter), 64'(c.exp_iter));
    chk("final_busy", 64'(o_busy), 64'd0);
    chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // one sweep is BEATS reads + PL drain cycles; done period = n*(960+2)+1 (+stall)
    cases[0] = '{num_iter:1, stall_at:-1, stall_len:0, abort_at:-1, busy_start_at:-1,
                 exp_done:963, exp_beats:960, exp_iter:1};
    cases[1] = '{num_iter:1, stall_at:10, stall_len:4, abort_at:-1, busy_start_at:-1,
                 exp_done:967, exp_beats:960, exp_iter:1};
    cases[2] = '{num_iter:1, stall_at:-1, stall_len:0, abort_at:500, busy_start_at:-1,
                 exp_done:-1, exp_beats:500, exp_iter:0};
    cases[3] = '{num_iter:1, stall_at:-1, stall_len:0, abort_at:-1, busy_start_at:100,
                 exp_done:963, exp_beats:960, exp_iter:1};
    cases[4] = '{num_iter:3, stall_at:-1, stall_len:0, abort_at:-1, busy_start_at:-1,
                 exp_done:2887, exp_beats:2880, exp_iter:3};
    cases[5] = '{num_iter:0, stall_at:-1, stall_len:0, abort_at:-1, busy_start_at:-1,
                 exp_done:1, exp_beats:0, exp_iter:0};

    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_stall = 1'b0; i_num_iter = 8'd0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    i_rst = 1'b0;

    for (int i = 0; i < 6; i++) run_case(cases[i]);

    // asynchronous reset in the second sweep of a two-sweep run
    @(posedge clk); #1;
    i_start = 1'b1; i_num_iter = 8'd2;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    chk("pre_reset_iter", 64'(o_iter), 64'd1);
    chk("pre_reset_busy", 64'(o_busy), 64'd1);
    #2 i_rst = 1'b1;
    #1 chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    chk_all_zero("reset_held");
    i_rst = 1'b0;
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      chk("post_reset_wr_en", 64'(o_wr_en), 64'd0);
      chk("post_reset_busy", 64'(o_busy), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
